// File: rtl/l1_mem_port_arbiter_if.sv
// Cache-style request/response port: requester drives valid/op/address/write data,
// responder returns a one-cycle ready pulse with the read block.
interface l1_mem_port_arbiter_if #(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128
);
  logic                  valid;
  logic                  r0w1;
  logic [BW_ADDRESS-1:0] rwaddr;
  logic [BW_BLOCK-1:0]   wdata;
  logic                  ready;
  logic [BW_BLOCK-1:0]   rdata;

  modport master (output valid, r0w1, rwaddr, wdata, input  ready, rdata);
  modport slave  (input  valid, r0w1, rwaddr, wdata, output ready, rdata);
endinterface

// File: rtl/l1_mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream block port between the I-side and D-side L1.
// Side index 0 is I, 1 is D; one transaction in flight, RESP bubble between grants.
module l1_mem_port_arbiter #(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128,
  parameter int BW_CNT     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  l1_mem_port_arbiter_if.slave  icache,
  l1_mem_port_arbiter_if.slave  dcache,
  l1_mem_port_arbiter_if.master mem,
  output logic [BW_CNT-1:0]     I_grant_cnt,
  output logic [BW_CNT-1:0]     D_grant_cnt
);
  localparam int NUM_SIDES = 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                             state, state_nxt;
  logic [NUM_SIDES-1:0]               req, rdy;
  logic [NUM_SIDES-1:0][BW_BLOCK-1:0] rdat;
  logic [NUM_SIDES-1:0][BW_CNT-1:0]   cnt;
  logic                               owner, last, win, grant, done;
  logic                               bus_vld, bus_r0w1;
  logic [BW_ADDRESS-1:0]              bus_addr;
  logic [BW_BLOCK-1:0]                bus_wdata;

  assign req   = {dcache.valid, icache.valid};
  // D wins if alone, or on a tie when I was served last
  assign win   = req[1] & (~req[0] | ~last);
  assign grant = (state == IDLE) & (|req);
  assign done  = (state == BUSY) & mem.ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant)     state_nxt = BUSY;
      BUSY:    if (mem.ready) state_nxt = RESP;
      RESP:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_vld   <= 1'b0;
      bus_r0w1  <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      owner     <= 1'b1;
      last      <= 1'b0;
      rdy       <= '0;
      rdat      <= '0;
      cnt       <= '0;
    end else begin
      rdy <= '0;
      if (grant) begin
        bus_vld   <= 1'b1;
        bus_r0w1  <= win ? dcache.r0w1   : icache.r0w1;
        bus_addr  <= win ? dcache.rwaddr : icache.rwaddr;
        bus_wdata <= win ? dcache.wdata  : icache.wdata;
        owner     <= win;
        last      <= win;
      end else if (done) begin
        bus_vld   <= 1'b0;
      end
      for (int s = 0; s < NUM_SIDES; s++) begin
        // a requester that abandoned its request gets no pulse and keeps its old block
        if (done && owner == 1'(s) && req[s]) begin
          rdy[s]  <= 1'b1;
          rdat[s] <= mem.rdata;
        end
        if (grant && win == 1'(s) && !(&cnt[s])) cnt[s] <= cnt[s] + 1'b1;
      end
    end
  end

  assign mem.valid    = bus_vld;
  assign mem.r0w1     = bus_r0w1;
  assign mem.rwaddr   = bus_addr;
  assign mem.wdata    = bus_wdata;
  assign icache.ready = rdy[0];
  assign icache.rdata = rdat[0];
  assign dcache.ready = rdy[1];
  assign dcache.rdata = rdat[1];
  assign I_grant_cnt  = cnt[0];
  assign D_grant_cnt  = cnt[1];
endmodule
